adt7310_measure_fsm: RTL and testbench

Measurement sequencer for the ADT7310 temperature sensor on the SPI master. On a start pulse from the sensor FSM it writes a one-shot conversion command, waits a programmable conversion time, reads the 16-bit temperature register, and returns both bytes with a done pulse. It sits between the sensor FSM (Start/Done/Byte0/Byte1) and the SPI master's TX/RX FIFO interface, and it drives the sensor's chip select.

---
 rtl/adt7310_measure_fsm.sv | 165 ++++++++++++++++
 tb/tb_adt7310_measure_fsm.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adt7310_measure_fsm.sv
// ADT7310 one-shot measurement sequencer: config write, conversion wait,
// 16-bit temperature read over the SPI master FIFO interface.
module adt7310_measure_fsm #(
    parameter int DataWidth = 8
) (
    input  logic                 Reset_n_i,
    input  logic                 Clk_i,
    input  logic                 Start_i,
    output logic                 Done_o,
    output logic [DataWidth-1:0] Byte0_o,
    output logic [DataWidth-1:0] Byte1_o,
    input  logic [15:0]          ParamConvWait_i,
    output logic                 SPI_Write_o,
    output logic [DataWidth-1:0] SPI_Data_o,
    output logic                 SPI_ReadNext_o,
    input  logic [DataWidth-1:0] SPI_Data_i,
    input  logic                 SPI_FIFOEmpty_i,
    input  logic                 SPI_Transmission_i,
    output logic                 ADT7310CS_n_o
);

    localparam logic [DataWidth-1:0] CmdWrCfg  = DataWidth'(8'h08);
    localparam logic [DataWidth-1:0] CfgOneShot = DataWidth'(8'h20);
    localparam logic [DataWidth-1:0] CmdRdTemp = DataWidth'(8'h50);
    localparam logic [DataWidth-1:0] DummyByte = DataWidth'(8'hFF);

    typedef enum logic [2:0] {
        stIdle,
        stCfgData,
        stCfgDrain,
        stConvWait,
        stRdDummy1,
        stRdDummy2,
        stRdDrain,
        stDone
    } state_t;

    state_t      state;
    state_t      stateNext;
    logic [1:0]  rxCnt;
    logic [15:0] timer;
    logic        rxCntClr;
    logic        timerLoad;
    logic        timerDec;
    logic        rdPop;

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state <= stIdle;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext      = state;
        Done_o         = 1'b0;
        SPI_Write_o    = 1'b0;
        SPI_Data_o     = '0;
        SPI_ReadNext_o = 1'b0;
        ADT7310CS_n_o  = 1'b1;
        rxCntClr       = 1'b0;
        timerLoad      = 1'b0;
        timerDec       = 1'b0;
        rdPop          = 1'b0;
        unique case (state)
            stIdle: begin
                if (Start_i) begin
                    SPI_Write_o = 1'b1;
                    SPI_Data_o  = CmdWrCfg;
                    stateNext   = stCfgData;
                end
            end
            stCfgData: begin
                ADT7310CS_n_o = 1'b0;
                SPI_Write_o   = 1'b1;
                SPI_Data_o    = CfgOneShot;
                rxCntClr      = 1'b1;
                stateNext     = stCfgDrain;
            end
            stCfgDrain: begin
                ADT7310CS_n_o  = 1'b0;
                SPI_ReadNext_o = !SPI_FIFOEmpty_i && (rxCnt != 2'd2);
                if (rxCnt == 2'd2 && !SPI_Transmission_i) begin
                    timerLoad = 1'b1;
                    stateNext = stConvWait;
                end
            end
            stConvWait: begin
                // read command is queued while CS is still high
                if (timer == 16'd0) begin
                    SPI_Write_o = 1'b1;
                    SPI_Data_o  = CmdRdTemp;
                    rxCntClr    = 1'b1;
                    stateNext   = stRdDummy1;
                end else begin
                    timerDec = 1'b1;
                end
            end
            stRdDummy1: begin
                ADT7310CS_n_o = 1'b0;
                SPI_Write_o   = 1'b1;
                SPI_Data_o    = DummyByte;
                stateNext     = stRdDummy2;
            end
            stRdDummy2: begin
                ADT7310CS_n_o = 1'b0;
                SPI_Write_o   = 1'b1;
                SPI_Data_o    = DummyByte;
                stateNext     = stRdDrain;
            end
            stRdDrain: begin
                ADT7310CS_n_o  = 1'b0;
                SPI_ReadNext_o = !SPI_FIFOEmpty_i && (rxCnt != 2'd3);
                rdPop          = SPI_ReadNext_o;
                if (rxCnt == 2'd3 && !SPI_Transmission_i) begin
                    stateNext = stDone;
                end
            end
            stDone: begin
                Done_o    = 1'b1;
                stateNext = stIdle;
            end
            default: begin
                stateNext = stIdle;
            end
        endcase
    end

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            rxCnt <= 2'd0;
        end else if (rxCntClr) begin
            rxCnt <= 2'd0;
        end else if (SPI_ReadNext_o) begin
            rxCnt <= rxCnt + 2'd1;
        end
    end

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            timer <= 16'd0;
        end else if (timerLoad) begin
            timer <= ParamConvWait_i;
        end else if (timerDec) begin
            timer <= timer - 16'd1;
        end
    end

    // first read pop is the byte clocked out during the command
    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            Byte0_o <= '0;
            Byte1_o <= '0;
        end else if (rdPop) begin
            if (rxCnt == 2'd1) begin
                Byte1_o <= SPI_Data_i;
            end
            if (rxCnt == 2'd2) begin
                Byte0_o <= SPI_Data_i;
            end
        end
    end

endmodule

// File: tb/tb_adt7310_measure_fsm.sv
// Bench for adt7310_measure_fsm with a queue-based SPI master/sensor model.
module tb_adt7310_measure_fsm;

    localparam int SHIFT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] param = 16'd0;
    logic        done;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic        wr;
    logic [7:0]  txd;
    logic        rn;
    logic [7:0]  rxd = 8'd0;
    logic        empty = 1'b1;
    logic        trans = 1'b0;
    logic        csn;

    always #5 clk = ~clk;

    adt7310_measure_fsm #(.DataWidth(8)) dut (
        .Reset_n_i(rst_n),
        .Clk_i(clk),
        .Start_i(start),
        .Done_o(done),
        .Byte0_o(b0),
        .Byte1_o(b1),
        .ParamConvWait_i(param),
        .SPI_Write_o(wr),
        .SPI_Data_o(txd),
        .SPI_ReadNext_o(rn),
        .SPI_Data_i(rxd),
        .SPI_FIFOEmpty_i(empty),
        .SPI_Transmission_i(trans),
        .ADT7310CS_n_o(csn)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // SPI master + sensor model
    typedef struct {
        logic [7:0] d;
        int         rdy;
    } pend_t;

    int         cyc = 0;
    logic [7:0] txq[$];
    logic [7:0] respQ[$];
    pend_t      pendQ[$];
    logic [7:0] rxq[$];
    pend_t      pn;
    int         shiftCnt = 0;
    int         rxIdx = 0;
    int         slowIdx = -1;
    logic       capWr = 1'b0;
    logic       capPop = 1'b0;
    logic [7:0] capData = 8'd0;

    always @(posedge clk) begin
        cyc++;
        #1;
        if (!rst_n) begin
            txq.delete();
            pendQ.delete();
            rxq.delete();
            shiftCnt = 0;
        end else begin
            if (capPop && rxq.size() > 0) void'(rxq.pop_front());
            if (capWr) txq.push_back(capData);
            if (shiftCnt > 0) begin
                shiftCnt--;
                if (shiftCnt == 0) begin
                    pn.d = (respQ.size() > 0) ? respQ.pop_front() : 8'h00;
                    pn.rdy = cyc + ((rxIdx == slowIdx) ? 20 : 0);
                    rxIdx++;
                    pendQ.push_back(pn);
                end
            end
            if (shiftCnt == 0 && txq.size() > 0) begin
                void'(txq.pop_front());
                shiftCnt = SHIFT;
            end
            while (pendQ.size() > 0 && pendQ[0].rdy <= cyc) begin
                pn = pendQ.pop_front();
                rxq.push_back(pn.d);
            end
        end
        empty = (rxq.size() == 0);
        rxd = empty ? 8'h00 : rxq[0];
        trans = (shiftCnt > 0) || (txq.size() > 0);
    end

    // observation logs
    logic [7:0] wrLog[$];
    int         wrCyc[$];
    int         csRise[$];
    int         doneCyc[$];
    logic [7:0] doneB0[$];
    logic [7:0] doneB1[$];
    int         popCyc[$];
    int         csHighRead = 0;
    logic       prevCs = 1'b1;

    always @(negedge clk) begin
        capWr = wr;
        capData = txd;
        capPop = rn;
        if (rst_n) begin
            checks++;
            if (!wr && txd !== 8'h00) begin
                errors++;
                $display("FAIL txidle: got %0h expected 0", txd);
            end
            checks++;
            if (rn && empty) begin
                errors++;
                $display("FAIL popempty: got pop=1 expected 0");
            end
            if (wr) begin
                wrLog.push_back(txd);
                wrCyc.push_back(cyc);
            end
            if (rn) popCyc.push_back(cyc);
            if (csn && !prevCs) csRise.push_back(cyc);
            if (done) begin
                doneCyc.push_back(cyc);
                doneB0.push_back(b0);
                doneB1.push_back(b1);
            end
            if (csn && wrCyc.size() >= 3 && doneCyc.size() == 0) begin
                if (cyc > wrCyc[2]) csHighRead++;
            end
        end
        prevCs = csn;
    end

    task automatic clearLogs();
        wrLog.delete();
        wrCyc.delete();
        csRise.delete();
        doneCyc.delete();
        doneB0.delete();
        doneB1.delete();
        popCyc.delete();
        csHighRead = 0;
    endtask

    task automatic startMeas(input logic [15:0] w, input logic [39:0] resp,
                             input int slow);
        logic [39:0] r;
        clearLogs();
        respQ.delete();
        r = resp;
        for (int i = 0; i < 5; i++) begin
            respQ.push_back(r[39:32]);
            r = r << 8;
        end
        rxIdx = 0;
        slowIdx = slow;
        param = w;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic finishMeas(input string tag, input logic [15:0] w,
                              input logic [7:0] e1, input logic [7:0] e0,
                              input bit slow);
        int n;
        logic [63:0] seq;
        int wlen;
        n = 0;
        while (doneCyc.size() == 0 && n < int'(w) + 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " done_seen"}, 64'(doneCyc.size() > 0), 64'd1);
        if (doneCyc.size() == 0) return;
        repeat (3) @(negedge clk);
        chk({tag, " ndone"}, 64'(doneCyc.size()), 64'd1);
        seq = 64'd0;
        foreach (wrLog[i]) seq = {seq[55:0], wrLog[i]};
        chk({tag, " txseq"}, seq, 64'h082050FFFF);
        wlen = -1;
        if (wrCyc.size() >= 3 && csRise.size() >= 1)
            wlen = wrCyc[2] - csRise[0] + 1;
        chk({tag, " convwait"}, 64'(wlen), 64'(int'(w) + 1));
        chk({tag, " byte1"}, 64'(doneB1[0]), 64'(e1));
        chk({tag, " byte0"}, 64'(doneB0[0]), 64'(e0));
        chk({tag, " cs_high_in_read"}, 64'(csHighRead), 64'd0);
        if (slow) begin
            chk({tag, " npop"}, 64'(popCyc.size()), 64'd5);
            if (popCyc.size() > 0)
                chk({tag, " done_after_pop"},
                    64'(doneCyc[0] - popCyc[popCyc.size()-1]), 64'd2);
        end
    endtask

    typedef struct {
        logic [15:0] w;
        logic [39:0] resp;
        logic [7:0]  e1;
        logic [7:0]  e0;
        bit          slow;
    } vec_t;

    vec_t       vt[4];
    logic [7:0] pat[5];

    initial begin
        int n;
        int bad;
        logic [15:0] rw;
        logic [39:0] rr;
        bit rs;

        vt[0] = '{16'd10,     40'h000000_0C80, 8'h0C, 8'h80, 1'b0};
        vt[1] = '{16'd0,      40'hAA5511_2233, 8'h22, 8'h33, 1'b0};
        vt[2] = '{16'd3,      40'h0000FF_7F01, 8'h7F, 8'h01, 1'b1};
        vt[3] = '{16'hFFFF,   40'h000000_1990, 8'h19, 8'h90, 1'b0};
        pat = '{8'h08, 8'h20, 8'h50, 8'hFF, 8'hFF};

        repeat (2) @(posedge clk);
        #1;
        chk("rst cs", 64'(csn), 64'd1);
        chk("rst done", 64'(done), 64'd0);
        chk("rst wr", 64'(wr), 64'd0);
        chk("rst txd", 64'(txd), 64'd0);
        chk("rst rn", 64'(rn), 64'd0);
        chk("rst b0", 64'(b0), 64'd0);
        chk("rst b1", 64'(b1), 64'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 4; i++) begin
            startMeas(vt[i].w, vt[i].resp, vt[i].slow ? 4 : -1);
            finishMeas($sformatf("vec%0d", i), vt[i].w, vt[i].e1, vt[i].e0,
                       vt[i].slow);
        end

        for (int i = 0; i < 4; i++) begin
            rw = 16'($urandom_range(0, 40));
            rr = {8'($urandom), 32'($urandom)};
            rs = 1'($urandom_range(0, 1));
            startMeas(rw, rr, rs ? 4 : -1);
            finishMeas($sformatf("rnd%0d", i), rw, 8'((rr >> 8) & 40'hFF),
                       8'(rr & 40'hFF), rs);
        end

        // Start held high: back-to-back measurements
        clearLogs();
        respQ.delete();
        rxIdx = 0;
        slowIdx = -1;
        param = 16'd5;
        @(posedge clk);
        #1 start = 1'b1;
        repeat (200) @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while ((wrLog.size() == 0 || doneCyc.size() * 5 != wrLog.size())
               && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("hold settle", 64'(n < 300), 64'd1);
        repeat (3) @(negedge clk);
        chk("hold ndone>=2", 64'(doneCyc.size() >= 2), 64'd1);
        chk("hold nwr", 64'(wrLog.size()), 64'(doneCyc.size() * 5));
        bad = 0;
        foreach (wrLog[i]) if (wrLog[i] !== pat[i % 5]) bad++;
        chk("hold seq", 64'(bad), 64'd0);
        for (int i = 1; i < doneCyc.size(); i++) begin
            if (5 * i < wrCyc.size())
                chk($sformatf("hold gap%0d", i),
                    64'(wrCyc[5*i] - doneCyc[i-1]), 64'd1);
        end

        // reset in the read drain after pop 1
        startMeas(16'd2, 40'h000011_5AA5, -1);
        n = 0;
        while (popCyc.size() < 4 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("rstmid reach", 64'(popCyc.size() >= 4), 64'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid cs", 64'(csn), 64'd1);
        chk("rstmid b1", 64'(b1), 64'd0);
        chk("rstmid b0", 64'(b0), 64'd0);
        chk("rstmid done", 64'(done), 64'd0);
        chk("rstmid wr", 64'(wr), 64'd0);
        chk("rstmid rn", 64'(rn), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        startMeas(16'd7, 40'h000000_2143, -1);
        finishMeas("postrst", 16'd7, 8'h21, 8'h43, 1'b0);

        // outputs hold between measurements
        startMeas(16'd4, 40'h000000_1234, -1);
        finishMeas("holdA", 16'd4, 8'h12, 8'h34, 1'b0);
        startMeas(16'd4, 40'h000000_ABCD, -1);
        n = 0;
        while (wrLog.size() < 3 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("holdB keep1", 64'(b1), 64'h12);
        chk("holdB keep0", 64'(b0), 64'h34);
        finishMeas("holdB", 16'd4, 8'hAB, 8'hCD, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
